zero_run_detector: RTL and testbench

Parametrised multichannel silence detector for the MSDAP input path. It generalises the two-channel 800-zero detector to NUM_CH channels of DATA_W bits, with a programmable near-zero threshold and an explicit ACTIVE/SLEEP state machine. It also produces entry and exit pulses that the controller uses to enter and leave sleep. It sits after the serial-to-parallel input stage and is strobed once per received sample frame.

---
 rtl/zero_run_detector.sv | 143 ++++++++++++++
 tb/tb_zero_run_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_run_detector.sv
// zero_run_detector: multichannel silence detector for the MSDAP input path.
// A frame (one enable strobe) is quiet when every channel sits inside the
// signed window [-ZERO_THRESH, ZERO_THRESH]. ZERO_LIMIT consecutive quiet
// frames move the detector from ACTIVE to SLEEP. The first non-quiet frame
// moves it back. Both transitions are flagged with one-cycle pulses.
// Optional feature macro: ZDET_PER_CH_EN adds per-channel run counters that
// drive ch_zero. When the macro is undefined, ch_zero is tied low.

// Per-lane signed window test. The sample is sign-extended by one bit so that
// -ZERO_THRESH is always representable. -2^(DATA_W-1) falls below any legal
// window, so it is never quiet.
module zrd_quiet #(
  parameter int DATA_W      = 16,
  parameter int ZERO_THRESH = 0
) (
  input  logic [DATA_W-1:0] sample,
  output logic              quiet
);
  localparam logic signed [DATA_W:0] THR = (DATA_W+1)'(ZERO_THRESH);

  logic signed [DATA_W:0] x;

  assign x     = {sample[DATA_W-1], sample};
  assign quiet = (x >= -THR) && (x <= THR);
endmodule

module zero_run_detector #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 16,
  parameter int ZERO_LIMIT  = 800,
  parameter int ZERO_THRESH = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              enable,
  input  logic [NUM_CH*DATA_W-1:0]          data,
  output logic                              all_zeros,
  output logic                              sleep_pulse,
  output logic                              wake_pulse,
  output logic [NUM_CH-1:0]                 ch_zero,
  output logic [$clog2(ZERO_LIMIT+1)-1:0]   zero_count
);
  localparam int             CW     = $clog2(ZERO_LIMIT+1);
  localparam logic [CW-1:0]  LIM    = CW'(ZERO_LIMIT);
  localparam logic [CW-1:0]  LIM_M1 = CW'(ZERO_LIMIT-1);

  typedef enum logic {ACTIVE = 1'b0, SLEEP = 1'b1} state_t;

  state_t              state;
  logic [NUM_CH-1:0]   ch_quiet;
  logic                frame_quiet;

  // One window comparator per channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    zrd_quiet #(.DATA_W(DATA_W), .ZERO_THRESH(ZERO_THRESH)) u_quiet (
      .sample (data[c*DATA_W +: DATA_W]),
      .quiet  (ch_quiet[c])
    );
  end

  assign frame_quiet = &ch_quiet;

  // Global ACTIVE/SLEEP machine. The pulses self-clear every cycle. clear wins
  // over a simultaneous strobe and never produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACTIVE;
      zero_count  <= '0;
      all_zeros   <= 1'b0;
      sleep_pulse <= 1'b0;
      wake_pulse  <= 1'b0;
    end else begin
      sleep_pulse <= 1'b0;
      wake_pulse  <= 1'b0;
      if (clear) begin
        state      <= ACTIVE;
        zero_count <= '0;
        all_zeros  <= 1'b0;
      end else if (enable) begin
        case (state)
          ACTIVE: begin
            if (!frame_quiet) begin
              zero_count <= '0;
            end else if (zero_count == LIM_M1) begin
              state       <= SLEEP;
              zero_count  <= LIM;
              all_zeros   <= 1'b1;
              sleep_pulse <= 1'b1;
            end else begin
              zero_count <= zero_count + CW'(1);
            end
          end
          SLEEP: begin
            // Quiet frames leave the saturated count alone. The waking frame
            // is itself not counted.
            if (!frame_quiet) begin
              state      <= ACTIVE;
              zero_count <= '0;
              all_zeros  <= 1'b0;
              wake_pulse <= 1'b1;
            end
          end
          default: state <= ACTIVE;
        endcase
      end
    end
  end

`ifdef ZDET_PER_CH_EN
  // Independent saturating run counter per channel. These do not feed back
  // into the global FSM.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_pc
    logic [CW-1:0] ch_cnt;
    logic          ch_flag;

    // Count this channel's quiet run. The flag rises when the run reaches the
    // limit and drops on the first loud sample.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ch_cnt  <= '0;
        ch_flag <= 1'b0;
      end else if (clear) begin
        ch_cnt  <= '0;
        ch_flag <= 1'b0;
      end else if (enable) begin
        if (ch_quiet[c]) begin
          if (ch_cnt != LIM)    ch_cnt  <= ch_cnt + CW'(1);
          if (ch_cnt == LIM_M1) ch_flag <= 1'b1;
        end else begin
          ch_cnt  <= '0;
          ch_flag <= 1'b0;
        end
      end
    end

    assign ch_zero[c] = ch_flag;
  end
`else
  assign ch_zero = '0;
`endif

endmodule

// File: tb/tb_zero_run_detector.sv
// Bench for zero_run_detector. It runs three configurations side by side on a
// shared strobe/clear:
//   A: 2ch, limit 4, thresh 0
//   B: 4ch, limit 4, thresh 2
//   C: 1ch, limit 1, thresh 32767
// The reference model tracks the length of the current quiet run as a plain
// integer. Sleep, count, pulses and ch_zero are all derived from that integer.
module tb_zero_run_detector;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] data_a;
  logic [63:0] data_b;
  logic [15:0] data_c;
  logic        az_a, sp_a, wp_a, az_b, sp_b, wp_b, az_c, sp_c, wp_c;
  logic [1:0]  cz_a;
  logic [3:0]  cz_b;
  logic [0:0]  cz_c;
  logic [2:0]  zc_a, zc_b;
  logic [0:0]  zc_c;

  zero_run_detector #(.NUM_CH(2), .DATA_W(16), .ZERO_LIMIT(4), .ZERO_THRESH(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .data(data_a),
    .all_zeros(az_a), .sleep_pulse(sp_a), .wake_pulse(wp_a), .ch_zero(cz_a), .zero_count(zc_a));
  zero_run_detector #(.NUM_CH(4), .DATA_W(16), .ZERO_LIMIT(4), .ZERO_THRESH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .data(data_b),
    .all_zeros(az_b), .sleep_pulse(sp_b), .wake_pulse(wp_b), .ch_zero(cz_b), .zero_count(zc_b));
  zero_run_detector #(.NUM_CH(1), .DATA_W(16), .ZERO_LIMIT(1), .ZERO_THRESH(32767)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .data(data_c),
    .all_zeros(az_c), .sleep_pulse(sp_c), .wake_pulse(wp_c), .ch_zero(cz_c), .zero_count(zc_c));

  int act_cnt[3], act_az[3], act_sp[3], act_wp[3], act_cz[3];
  always_comb begin
    act_cnt[0] = int'(zc_a); act_az[0] = int'(az_a); act_sp[0] = int'(sp_a);
    act_wp[0]  = int'(wp_a); act_cz[0] = int'(cz_a);
    act_cnt[1] = int'(zc_b); act_az[1] = int'(az_b); act_sp[1] = int'(sp_b);
    act_wp[1]  = int'(wp_b); act_cz[1] = int'(cz_b);
    act_cnt[2] = int'(zc_c); act_az[2] = int'(az_c); act_sp[2] = int'(sp_c);
    act_wp[2]  = int'(wp_c); act_cz[2] = int'(cz_c);
  end

  int NCH[3] = '{2, 4, 1};
  int LIM[3] = '{4, 4, 1};
  int THR[3] = '{0, 2, 32767};
`ifdef ZDET_PER_CH_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  int frame[4];
  int run[3];
  int chrun[3][4];
  int exp_cnt[3], exp_az[3], exp_sp[3], exp_wp[3], exp_cz[3];
  int checks = 0, errors = 0;

  typedef struct {
    bit en, clr;
    int d0, d1;
    int cnt, az, sp, wp;
  } vec_t;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      run[i] = 0;
      exp_sp[i] = 0; exp_wp[i] = 0; exp_cnt[i] = 0; exp_az[i] = 0; exp_cz[i] = 0;
      for (int c = 0; c < 4; c++) chrun[i][c] = 0;
    end
  endtask

  task automatic model_step(bit en, bit clr);
    for (int i = 0; i < 3; i++) begin
      bit q, cq;
      int prev;
      exp_sp[i] = 0;
      exp_wp[i] = 0;
      if (clr) begin
        run[i] = 0;
        for (int c = 0; c < 4; c++) chrun[i][c] = 0;
      end else if (en) begin
        q = 1'b1;
        for (int c = 0; c < NCH[i]; c++) begin
          cq = (frame[c] >= -THR[i]) && (frame[c] <= THR[i]);
          chrun[i][c] = cq ? chrun[i][c] + 1 : 0;
          if (chrun[i][c] > LIM[i] + 1) chrun[i][c] = LIM[i] + 1;
          q &= cq;
        end
        prev   = run[i];
        run[i] = q ? run[i] + 1 : 0;
        if (run[i] > LIM[i] + 1) run[i] = LIM[i] + 1;
        exp_sp[i] = int'(q && run[i] == LIM[i]);
        exp_wp[i] = int'(!q && prev >= LIM[i]);
      end
      exp_az[i]  = int'(run[i] >= LIM[i]);
      exp_cnt[i] = (run[i] < LIM[i]) ? run[i] : LIM[i];
      exp_cz[i]  = 0;
      for (int c = 0; c < NCH[i]; c++)
        if (PC_EN && chrun[i][c] >= LIM[i]) exp_cz[i] |= (1 << c);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cnt[%0d]", i), act_cnt[i], exp_cnt[i]);
      check($sformatf("all_zeros[%0d]", i), act_az[i], exp_az[i]);
      check($sformatf("sleep_pulse[%0d]", i), act_sp[i], exp_sp[i]);
      check($sformatf("wake_pulse[%0d]", i), act_wp[i], exp_wp[i]);
      check($sformatf("ch_zero[%0d]", i), act_cz[i], exp_cz[i]);
    end
  endtask

  task automatic set_frame(int a, int b, int c, int d);
    frame[0] = a; frame[1] = b; frame[2] = c; frame[3] = d;
  endtask

  task automatic step(bit en, bit clr);
    @(negedge clk);
    enable = en;
    clear  = clr;
    data_a = {16'(frame[1]), 16'(frame[0])};
    data_b = {16'(frame[3]), 16'(frame[2]), 16'(frame[1]), 16'(frame[0])};
    data_c = 16'(frame[0]);
    @(posedge clk);
    #1;
    model_step(en, clr);
    check_all();
  endtask

  vec_t tbl[21];

  initial begin
    // Hand-derived expectations for config A (limit 4, exact zero)
    tbl[0]  = '{1, 0, 0, 0,      1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0,      2, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0,      3, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0,      4, 1, 1, 0};
    tbl[4]  = '{0, 0, 77, -9,    4, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, -1,     0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0,      1, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0,      2, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0,      3, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 0,      0, 0, 0, 0};
    tbl[10] = '{0, 0, 5, 5,      0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0,      1, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0,      2, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0,      3, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0,      4, 1, 1, 0};
    tbl[15] = '{1, 0, 0, 0,      4, 1, 0, 0};
    tbl[16] = '{1, 1, 3, 3,      0, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0,      1, 0, 0, 0};
    tbl[18] = '{1, 0, 0, 0,      2, 0, 0, 0};
    tbl[19] = '{1, 1, 0, 0,      0, 0, 0, 0};
    tbl[20] = '{1, 0, 0, 0,      1, 0, 0, 0};

    data_a = '0; data_b = '0; data_c = '0;
    set_frame(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;

    // Table-driven sequences on A. The model also checks B and C each step.
    for (int k = 0; k < 21; k++) begin
      set_frame(tbl[k].d0, tbl[k].d1, 0, 0);
      step(tbl[k].en, tbl[k].clr);
      check($sformatf("tbl%0d_cnt", k), act_cnt[0], tbl[k].cnt);
      check($sformatf("tbl%0d_az", k), act_az[0], tbl[k].az);
      check($sformatf("tbl%0d_sp", k), act_sp[0], tbl[k].sp);
      check($sformatf("tbl%0d_wp", k), act_wp[0], tbl[k].wp);
    end

    // Threshold window on B: {2,-2,0,1} is quiet at thresh 2
    step(1, 1);
    set_frame(2, -2, 0, 1);
    repeat (4) step(1, 0);
    check("b_sleep", act_az[1], 1);
    check("b_sleep_pulse", act_sp[1], 1);
    set_frame(3, 0, 0, 0);
    step(1, 0);
    check("b_wake", act_wp[1], 1);
    check("b_wake_cnt", act_cnt[1], 0);
    // The most negative code is never quiet, even with the widest window
    set_frame(-32768, 0, 0, 0);
    step(1, 0);
    check("c_min_wake", act_wp[2], 1);
    check("c_min_cnt", act_cnt[2], 0);
    step(1, 0);
    check("c_min_cnt_hold", act_cnt[2], 0);

    // Per-channel runs: ch0 stays quiet while ch1 stays loud
    step(1, 1);
    set_frame(0, 5, 0, 0);
    repeat (4) step(1, 0);
    check("pc_cz_a", act_cz[0], PC_EN ? 1 : 0);
    check("pc_az_a", act_az[0], 0);
    set_frame(5, 5, 0, 0);
    step(1, 0);
    check("pc_cz_a_fall", act_cz[0], 0);

    // Asynchronous reset while A sleeps, asserted between clock edges
    step(1, 1);
    set_frame(0, 0, 0, 0);
    repeat (4) step(1, 0);
    check("pre_rst_sleep", act_az[0], 1);
    @(negedge clk);
    enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the run-length model
    for (int n = 0; n < 600; n++) begin
      int mode;
      bit en, clr;
      mode = int'($urandom_range(0, 9));
      for (int c = 0; c < 4; c++) begin
        if (mode < 6)      frame[c] = 0;
        else if (mode < 8) frame[c] = int'($urandom_range(0, 6)) - 3;
        else if ($urandom_range(0, 1) == 0) frame[c] = 0;
        else if ($urandom_range(0, 3) == 0) frame[c] = -32768;
        else frame[c] = int'($urandom_range(0, 65535)) - 32768;
      end
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      step(en, clr);
    end

    @(negedge clk);
    enable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
